// File: rtl/tbird_input_cond.sv
// Input conditioning for the T-bird tail-light controller: per-channel 2-flop
// synchronizer plus saturating debounce counter, with optional hazard press-to-toggle.
module tbird_input_cond #(
  parameter int DB_CYCLES  = 16,
  parameter int CNT_W      = $clog2(DB_CYCLES),
  parameter bit HAZ_TOGGLE = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic left_raw,
  input  logic right_raw,
  input  logic haz_raw,
  output logic left,
  output logic right,
  output logic haz
);

  localparam int unsigned NCH = 3;
  localparam int unsigned CH_L = 0;
  localparam int unsigned CH_R = 1;
  localparam int unsigned CH_H = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   db;
  logic [NCH-1:0]   db_nxt;
  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];

  assign raw = {haz_raw, right_raw, left_raw};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count only while the synchronized level disagrees with db; any agreeing cycle restarts at 0.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      db_nxt[i]  = db[i];
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      db <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db <= db_nxt;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign left  = db[CH_L];
  assign right = db[CH_R];

  generate
    if (HAZ_TOGGLE) begin : g_haz_toggle
      logic haz_lat;

      // Toggle on the same edge db_H rises, so haz keeps the same latency as left/right.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          haz_lat <= 1'b0;
        end else if (!db[CH_H] && db_nxt[CH_H]) begin
          haz_lat <= ~haz_lat;
        end
      end

      assign haz = haz_lat;
    end else begin : g_haz_level
      assign haz = db[CH_H];
    end
  endgenerate

endmodule

// File: tb/tb_tbird_input_cond.sv
// Scoreboard bench for tbird_input_cond: a level-mode and a toggle-mode instance share
// inputs; stimulus queues expected output changes, a monitor pops them as outputs move.
module tb_tbird_input_cond;

  localparam int LAT = 18;

  logic clk;
  logic rst_b;
  logic left_raw, right_raw, haz_raw;
  logic l_a, r_a, h_a;
  logic l_b, r_b, h_b;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } ev_t;

  ev_t q[$];
  int  cyc;
  int  total;
  int  bad;

  tbird_input_cond #(.DB_CYCLES(16), .HAZ_TOGGLE(1'b0)) u_lvl (
    .clk(clk), .rst_b(rst_b),
    .left_raw(left_raw), .right_raw(right_raw), .haz_raw(haz_raw),
    .left(l_a), .right(r_a), .haz(h_a)
  );

  tbird_input_cond #(.DB_CYCLES(16), .HAZ_TOGGLE(1'b1)) u_tog (
    .clk(clk), .rst_b(rst_b),
    .left_raw(left_raw), .right_raw(right_raw), .haz_raw(haz_raw),
    .left(l_b), .right(r_b), .haz(h_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic l, input logic r, input logic hl, input logic ht);
    ev_t e;
    e.cyc = c;
    e.v   = {l, r, hl, l, r, ht};
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({l_a, r_a, h_a, l_b, r_b, h_b} !== 6'b0) begin
      bad++;
      $display("FAIL %s got=%b want=000000", name, {l_a, r_a, h_a, l_b, r_b, h_b});
    end
  endtask

  // Monitor: samples 2 time units after each rising edge and pops on every output change.
  initial begin
    logic [5:0] prev;
    logic [5:0] obs;
    ev_t        e;
    prev = '0;
    cyc  = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      obs = {l_a, r_a, h_a, l_b, r_b, h_b};
      if (obs !== prev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b was=%b want=no change", cyc, obs, prev);
        end else begin
          e = q.pop_front();
          total++;
          if (e.cyc != cyc) begin
            bad++;
            $display("FAIL change_cycle got=%0d want=%0d", cyc, e.cyc);
          end
          total++;
          if (obs !== e.v) begin
            bad++;
            $display("FAIL change_value cyc=%0d got=%b want=%b", cyc, obs, e.v);
          end
        end
        prev = obs;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_change cyc=%0d got=%b want=%b by cyc %0d", cyc, obs, e.v, e.cyc);
      end
    end
  end

  initial begin
    int c;
    total     = 0;
    bad       = 0;
    rst_b     = 1'b0;
    left_raw  = 1'b1;
    right_raw = 1'b1;
    haz_raw   = 1'b1;

    // Reset with all inputs high, then release: everything rises on the 18th edge.
    wait_neg(3);
    check_zero("reset_state");
    rst_b = 1'b1;
    c = cyc;
    expect_at(c + LAT, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_neg(30);

    // Releasing everything: level outputs fall, toggle hazard holds.
    left_raw  = 1'b0;
    right_raw = 1'b0;
    haz_raw   = 1'b0;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_neg(30);

    // Bounce: left toggles every 3 cycles, ending high.
    for (int k = 0; k < 33; k++) begin
      left_raw = ~left_raw;
      c = cyc;
      if (k != 32) wait_neg(3);
    end
    expect_at(c + LAT, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_neg(30);
    left_raw = 1'b0;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_neg(30);

    // Glitch: 15 cycles high, 1 low, then high; count restarts from the final rise.
    right_raw = 1'b1;
    wait_neg(15);
    right_raw = 1'b0;
    wait_neg(1);
    right_raw = 1'b1;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_neg(30);
    right_raw = 1'b0;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_neg(30);

    // Asynchronous reset clears the latched hazard without waiting for a clock.
    c = cyc;
    expect_at(c + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check_zero("async_reset_haz");
    wait_neg(3);
    rst_b = 1'b1;
    wait_neg(5);

    // Two clean hazard presses: toggle goes 0->1 then 1->0, releases do nothing.
    haz_raw = 1'b1;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_neg(40);
    haz_raw = 1'b0;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_neg(40);
    haz_raw = 1'b1;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_neg(40);
    haz_raw = 1'b0;
    c = cyc;
    expect_at(c + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_neg(40);

    // Simultaneous left/right with reset pulsed while the counters are at 10.
    left_raw  = 1'b1;
    right_raw = 1'b1;
    wait_neg(12);
    rst_b = 1'b0;
    wait_neg(3);
    rst_b = 1'b1;
    c = cyc;
    expect_at(c + LAT, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_neg(30);

    // Reset while left/right are high drops them immediately.
    c = cyc;
    expect_at(c + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check_zero("async_reset_lr");
    left_raw  = 1'b0;
    right_raw = 1'b0;
    wait_neg(5);
    rst_b = 1'b1;
    wait_neg(25);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tbird_input_cond.md
# tbird_input_cond

Input conditioning stage for the T-bird tail-light controller. It sits directly upstream of the light-sequencing FSM and turns the three raw, asynchronous, bouncing dashboard switches (left, right, hazard) into clean, synchronous, debounced levels on `left`, `right` and `haz`. Optionally it turns the hazard push-button into a press-to-toggle latched hazard request.

## Interface
Parameters:
- `DB_CYCLES`, default 16: number of consecutive clock cycles a synchronized input must differ from the debounced value before the debounced value changes. Legal values are 2 or more.
- `CNT_W`, default `$clog2(DB_CYCLES)`: debounce counter width.
- `HAZ_TOGGLE`, default 1: selects the hazard mode. 1 means each debounced press toggles the hazard request. 0 means `haz` follows the debounced switch level.

Ports:
- `clk`, input, 1: system clock, rising-edge active.
- `rst_b`, input, 1: asynchronous, active-low reset.
- `left_raw`, input, 1: raw left-turn switch. Asynchronous and bouncing.
- `right_raw`, input, 1: raw right-turn switch. Asynchronous and bouncing.
- `haz_raw`, input, 1: raw hazard switch or button. Asynchronous and bouncing.
- `left`, output, 1: debounced left request, sent to the FSM.
- `right`, output, 1: debounced right request, sent to the FSM.
- `haz`, output, 1: hazard request, sent to the FSM. Debounced level or latched toggle, per `HAZ_TOGGLE`.

## Operation
- There are three identical channels: L, R and H. Each channel has the following logic.
  - A 2-flop synchronizer, `s1` then `s2`. The synchronizer output is `s2`.
  - A debounced state bit `db`.
  - A counter `cnt` of width `CNT_W`.
- Per-channel counter rules, evaluated on every rising edge:
  - If `s2 == db`: `cnt <= 0`. `db` holds.
  - If `s2 != db` and `cnt < DB_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != db` and `cnt == DB_CYCLES-1`: `db <= s2` and `cnt <= 0`.
- A glitch shorter than `DB_CYCLES` synchronized cycles never changes `db`. Any cycle with `s2 == db` restarts the count from 0.
- The counter never exceeds `DB_CYCLES-1`. There is no wrap-around.
- `left = db_L` and `right = db_R`. Both are outputs of registers.
- Hazard output with `HAZ_TOGGLE=1`:
  - Register `haz_lat` toggles on the same edge where `db_H` goes from 0 to 1.
  - A 1-to-0 transition of `db_H` has no effect.
  - `haz = haz_lat`.
- Hazard output with `HAZ_TOGGLE=0`: `haz = db_H`.
- Channels are fully independent. Simultaneous changes on several raw inputs are each debounced separately and may update on the same edge.
- The block does not arbitrate between inputs. `left`, `right` and `haz` may all be 1 at once. The FSM gives priority to `haz` and to the `left&right` combination.

## Timing
- Reset values: all `s1`, `s2`, `db`, `cnt` and `haz_lat` are 0. `left`, `right` and `haz` are 0 immediately on `rst_b` low, with no clock required.
- Reset asserted mid-count or mid-toggle: all state clears at once.
- After reset is released, a raw input that is already high is treated as a fresh 0-to-1 change.
- Latency: assume a raw input changes before rising edge N and then stays stable. The output changes on edge N+1+`DB_CYCLES`, which is `DB_CYCLES+2` edges counting edge N.
  - With the default of 16, that is 18 edges.
  - The delay is the same for 0-to-1 and 1-to-0 transitions.
- Toggle mode: `haz` changes on the same edge as `db_H` rises, at the same latency as `left`.
- A second press must be released and then pressed again. The release and the new press must each be debounced.
- All outputs are registered. There is no combinational path from any raw input to any output.
- Only synchronous update logic follows the synchronizer. No handshake with the FSM is used.

## Test plan
- Reset and latency:
  - Stimulus: hold `rst_b`=0 with all raw inputs at 1, then release reset.
  - Required response: `left`, `right` and `haz` stay 0 for 17 edges and go to 1 on the 18th edge (`DB_CYCLES`=16, `HAZ_TOGGLE`=0).
- Bounce rejection:
  - Stimulus: `left_raw` toggles every 3 cycles for 100 cycles, then stays at 1.
  - Required response: `left` stays 0 until exactly 18 edges after the last toggle, then goes to 1 with no further glitches.
- Glitch restart:
  - Stimulus: `right_raw` at 1 for 15 cycles, 0 for 1 cycle, then at 1.
  - Required response: `right` rises 18 edges after the final 0-to-1 change, not earlier.
- Hazard toggle (`HAZ_TOGGLE`=1):
  - Stimulus: two clean 40-cycle presses of `haz_raw` separated by 40 cycles of release.
  - Required response: `haz` goes 0 to 1 after the first press and 1 to 0 after the second. Each change lands 18 edges after the corresponding raw rise. Releases cause no change.
- Simultaneous inputs and mid-operation reset:
  - Stimulus: `left_raw` and `right_raw` rise on the same cycle, and `rst_b` is pulsed low at count 10.
  - Required response: both outputs are 0 through the reset. After release both rise on the same edge, 18 edges later.
